// File: rtl/button_toggle_gen_pkg.sv
// -----------------------------------------------------------------------------
// button_toggle_pkg
// Shared types and constants for the button toggle generator:
//   - state_t : FSM state encoding
//   - CNT_W   : width of the shared debounce/hold/repeat counter, sized so the
//               largest legal timing parameter (65535) fits without overflow
//   - PCNT_W  : width of the issued-pulse counter
// -----------------------------------------------------------------------------
package button_toggle_pkg;

  localparam int unsigned MAX_PARAM = 65535;
  localparam int unsigned CNT_W     = $clog2(MAX_PARAM + 1);
  localparam int unsigned PCNT_W    = 8;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [PCNT_W-1:0] pcnt_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/button_toggle_gen_if.sv
// -----------------------------------------------------------------------------
// button_toggle_gen_if
// Button-side signal bundle of the toggle generator.
//   btn_in    : raw push-button level (1 = pressed)
//   repeat_en : enable auto-repeat while held
//   t_out     : single-cycle toggle request
//   btn_level : debounced button level
//   pulse_cnt : number of t_out pulses since reset (wraps)
// master = stimulus side, slave = generator side.
// -----------------------------------------------------------------------------
interface button_toggle_gen_if;
  import button_toggle_pkg::*;

  logic  btn_in;
  logic  repeat_en;
  logic  t_out;
  logic  btn_level;
  pcnt_t pulse_cnt;

  modport master (output btn_in, output repeat_en,
                  input  t_out,  input  btn_level, input pulse_cnt);
  modport slave  (input  btn_in, input  repeat_en,
                  output t_out,  output btn_level, output pulse_cnt);
endinterface

// File: rtl/button_toggle_gen_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   reset : asynchronous, active-high; clears both flops to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output (two-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make both flops sample their old values on
  // the same edge; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_toggle_gen.sv
// -----------------------------------------------------------------------------
// button_toggle_gen
// Debounces a push button and issues single-cycle toggle requests for a
// downstream negedge T flip-flop: one on each accepted press, then optional
// auto-repeat pulses while the button stays held.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : button_toggle_gen_if.slave (btn_in, repeat_en -> t_out,
//           btn_level, pulse_cnt)
// Parameters: DEBOUNCE_CYCLES (2..255), REPEAT_DELAY (2..65535),
//             REPEAT_PERIOD (2..65535).
// -----------------------------------------------------------------------------
module button_toggle_gen
  import button_toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic                clk,
  input  logic                reset,
  button_toggle_gen_if.slave  bus
);

  // Compare values: the counter holds the number of samples/cycles already
  // seen, so the current sample is the last one when the count is N-1.
  localparam cnt_t DEB_LAST    = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t DELAY_CNT   = cnt_t'(REPEAT_DELAY);
  localparam cnt_t PERIOD_LAST = cnt_t'(REPEAT_PERIOD - 1);

  logic   btn_s;
  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   arm_q, arm_d;       // press accepted last edge: pulse on this edge
  logic   rep_fire;           // auto-repeat pulse due on this edge
  logic   t_out_q, t_out_d;
  pcnt_t  pcnt_q, pcnt_d;
  logic   btn_level;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.btn_in),
    .q_o   (btn_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      t_out_q <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      t_out_q <= t_out_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Next-state and counter logic. One counter serves debounce, hold delay
  // and repeat period, since only one of them is live in any state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    arm_d    = 1'b0;
    rep_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DEB_PRESS;
          cnt_d   = cnt_t'(1);
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          arm_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = cnt_t'(1);
        end else if (!bus.repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == DELAY_CNT) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          rep_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = cnt_t'(1);
        end else if (!bus.repeat_en) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          cnt_d    = '0;
          rep_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      DEB_RELEASE: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs. The press pulse is issued one cycle after HELD is entered, so
  // the level is already up when the downstream flop toggles.
  always_comb begin
    t_out_d   = arm_q | rep_fire;
    pcnt_d    = pcnt_q + {{(PCNT_W-1){1'b0}}, t_out_d};
    btn_level = (state_q == HELD) || (state_q == REPEAT) ||
                (state_q == DEB_RELEASE);
  end

  assign bus.t_out     = t_out_q;
  assign bus.btn_level = btn_level;
  assign bus.pulse_cnt = pcnt_q;

endmodule

// File: doc/button_toggle_gen.md
BUTTON_TOGGLE_GEN -- requirements
Module: button_toggle_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16, consecutive synchronized samples required to accept a level change (legal range 2..255).
REQ-002 Parameter REPEAT_DELAY, 64, cycles a press must be held before auto-repeat starts (legal range 2..65535).
REQ-003 Parameter REPEAT_PERIOD, 16, cycles between auto-repeat pulses (legal range 2..65535).
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 btn_in  input  1  raw, bouncy, asynchronous push-button level; 1 = pressed.
REQ-007 repeat_en  input  1  synchronous enable for auto-repeat while the button is held.
REQ-008 t_out  output  1  single-cycle toggle request that drives the T input of the downstream negedge T flip-flop.
REQ-009 btn_level  output  1  debounced button level.
REQ-010 pulse_cnt  output  8  count of t_out pulses issued since reset.

Function
REQ-011 btn_in SHALL pass through a 2-flop synchronizer; the synchronizer output btn_s is the only internal use of btn_in.
REQ-012 FSM states SHALL be IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE.
REQ-013 IDLE: btn_s=1 -> DEB_PRESS, with the debounce counter loaded to 1.
REQ-014 DEB_PRESS: each btn_s=1 sample increments the counter; any btn_s=0 sample -> IDLE with the counter cleared and no pulse.
REQ-015 On the DEBOUNCE_CYCLES-th consecutive high sample, the FSM SHALL enter HELD, set btn_level=1, and assert t_out for exactly the next cycle.
REQ-016 Latency from the first clock edge sampling btn_in=1 (stable) to t_out=1 SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-017 HELD: the hold counter increments every cycle while repeat_en=1.
  - On reaching REPEAT_DELAY: pulse t_out, move to REPEAT, clear the counter.
  - While repeat_en=0: the counter holds at 0 and no pulse is issued.
REQ-018 REPEAT: pulse t_out every REPEAT_PERIOD cycles.
  - repeat_en=0 -> HELD with the counter cleared; no pulse in that cycle.
REQ-019 HELD or REPEAT with btn_s=0 -> DEB_RELEASE with the counter at 1.
REQ-020 DEB_RELEASE: needs DEBOUNCE_CYCLES consecutive low samples to reach IDLE and clear btn_level.
  - Any high sample returns to HELD, with the hold counter cleared and no pulse.
  - btn_level stays 1 throughout DEB_RELEASE.
REQ-021 t_out SHALL be driven from a register clocked on the rising edge, so it is stable across the following falling edge.
REQ-022 t_out SHALL never be high for two consecutive cycles.
REQ-023 pulse_cnt SHALL increment by 1 in the cycle t_out=1 and wrap from 255 to 0.
REQ-024 Counter widths SHALL be sized from the largest parameter; a counter SHALL never overflow before it is compared.

Reset
REQ-025 Asserting reset SHALL immediately force:
  - synchronizer flops = 0
  - FSM = IDLE
  - all counters = 0
  - t_out = 0
  - btn_level = 0
  - pulse_cnt = 0
REQ-026 Reset asserted mid-press SHALL abort without a pulse.
REQ-027 After reset release with btn_in held at 1, a full DEB_PRESS sequence SHALL be required before any pulse.

Structure
REQ-028 Package button_toggle_pkg SHALL hold the FSM state encoding constants and the counter-width constant.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, asynchronous active-high reset to 0).
REQ-030 The FSM, counters and output registers SHALL reside in button_toggle_gen.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-031 Clean press: btn_in 0->1 held for 20 cycles, repeat_en=0 -> exactly one t_out pulse, 6 cycles after the first high sample; btn_level=1; pulse_cnt=1.
REQ-032 Bounce: btn_in pattern 1,1,0,1,1,1,0 then stable 0 -> no t_out pulse, btn_level stays 0.
REQ-033 Auto-repeat: press held with repeat_en=1 -> first pulse at cycle 6, second pulse 8 cycles later, then one pulse every 3 cycles.
  - repeat_en dropped -> pulses stop the next cycle.
REQ-034 Release bounce: while HELD, btn_in 0,0,1 then stable 1 -> btn_level stays 1 and no pulse occurs.
  - Then stable 0 for 4 samples -> btn_level=0 and the FSM is in IDLE.
REQ-035 Reset mid-operation: reset asserted during DEB_PRESS on count 3 -> all outputs 0 immediately.
  - With btn_in still 1 after release, the next pulse occurs 6 cycles after release.
REQ-036 Wrap and integration: 256 presses -> pulse_cnt returns to 0.
  - t_out drives t_ff_negedge: Q toggles once per pulse, and t_out is stable at every falling clk edge.
